branch_predict_unit: RTL and testbench
======================================

// Module: branch_predict_unit
// PURPOSE
//  Parametrised successor to the combinational branch comparator. Predicts in IF via a direct-mapped BHT+BTB
//  (saturating counters + tagged targets); resolves in EX with a 1-cycle registered stage. Raises mispredict/redirect
//  to the fetch unit and trains the tables from that registered stage.
// PARAMETERS
//  ENTRIES   64  table depth, power of 2, >=2; IDX_W=$clog2(ENTRIES), index = pc[IDX_W+1:2]
//  CNT_W     2   saturating counter width, >=1; predict taken when counter MSB=1
//  TAG_W     -   localparam = DATA_WIDTH-IDX_W-2, tag = pc[DATA_WIDTH-1:IDX_W+2]
// PORTS
//  clk_i            in   1           clock, all state on rising edge
//  rst_i            in   1           synchronous, active-high reset
//  pc_i             in   DATA_WIDTH  IF-stage fetch PC
//  pred_taken_o     out  1           prediction for pc_i (combinational)
//  pred_target_o    out  DATA_WIDTH  predicted target for pc_i (combinational)
//  resolve_valid_i  in   1           EX holds a branch/jump to resolve
//  branch_op_i      in   3           BRANCH_* encoding from pkg_config
//  a_i, b_i         in   DATA_WIDTH  compare operands (rs1, rs2)
//  resolve_pc_i     in   DATA_WIDTH  PC of the resolving instruction
//  target_i         in   DATA_WIDTH  computed target (branch/JAL/JALR)
//  pred_taken_i     in   1           prediction carried down the pipe with this instruction
//  pred_target_i    in   DATA_WIDTH  predicted target carried with it
//  flush_i          in   1           kill the resolve entering this cycle
//  taken_o          out  1           registered actual outcome
//  mispredict_o     out  1           registered, 1-cycle pulse per mispredicted resolve
//  redirect_pc_o    out  DATA_WIDTH  registered correct next PC, valid when mispredict_o=1
// BEHAVIOUR
//  Reset: counters = 2**(CNT_W-1)-1 (weakly not-taken), all BTB valid=0, taken_o=0, mispredict_o=0, redirect_pc_o=0.
//   Takes one cycle. While rst_i=1, resolves are ignored and tables are not written.
//  Predict (comb): hit = valid[idx] && tag[idx]==pc tag. pred_taken_o = hit && cnt[idx][CNT_W-1].
//   pred_target_o = hit ? tgt[idx] : pc_i+4. Not-hit -> pred_taken_o=0.
//  Resolve compare (comb in EX): BEQ/BNE/BLT/BGE (signed)/BLTU/BGEU as the ISA defines. BRANCH_JAL_JALR is always taken.
//   Undefined op -> not taken.
//  Stage register (edge after resolve_valid_i=1 && !flush_i): the outputs become valid one cycle later.
//   taken_o  <= actual taken.
//   mispredict_o <= (taken!=pred_taken_i) || (taken && target_i!=pred_target_i).
//   redirect_pc_o <= taken ? target_i : resolve_pc_i+4 (mod 2**DATA_WIDTH, wraps at top).
//   If resolve_valid_i=0 or flush_i=1: mispredict_o<=0; taken_o and redirect_pc_o hold.
//  Update (same edge as the stage register, from the resolve inputs, only when the resolve is accepted):
//   counter: saturating +1 if taken, -1 if not. Clamps at 0 and 2**CNT_W-1; no wrap.
//   If tag missed, the counter is reinitialised as though it were the weakly state, then stepped.
//   BTB: taken -> valid<=1, tag<=resolve tag, tgt<=target_i. Not-taken on a miss -> BTB entry untouched.
//  Simultaneous predict and update to the same index: the predict path sees the pre-update (old) value. No bypass.
//  A single update port; exactly one update per accepted resolve. Back-to-back resolves each update in order.
//  flush_i and resolve_valid_i asserted together: no table write, no pulse.
//  Reset asserted mid-operation overrides everything on that edge.
// STRUCTURE
//  pkg_config: existing DATA_WIDTH and BRANCH_* ops; add typedef btb_entry_t {valid, tag, tgt}.
//   Also add BP_ENTRIES_DEF and BP_CNT_W_DEF constants.
//  Sub-module sat_counter #(CNT_W) holds the inc/dec/clamp logic and is instantiated once on the update path.
//   The table arrays themselves stay in this module as flop arrays (the synchronous reset requires this).
// TESTING
//  1. Reset, then pc_i=0x100 -> pred_taken_o=0, pred_target_o=0x104. All outputs 0 during and after reset.
//  2. BEQ a=b=5 at pc 0x100, target 0x200, pred_taken_i=0
//     -> next cycle taken_o=1, mispredict_o=1, redirect_pc_o=0x200.
//     Then pc_i=0x100 -> pred_taken_o=1, pred_target_o=0x200.
//  3. CNT_W=2: 3 taken resolves, then 1 not-taken at the same pc -> counter 1->2->3->3->2, prediction still taken.
//     Then 1 more not-taken -> counter 1, pred_taken_o=0.
//  4. BLT a=-1, b=1 -> taken; BLTU with the same operands -> not taken.
//     Prediction correct -> mispredict_o=0. Wrong target on taken -> mispredict_o=1.
//  5. Aliasing: pc 0x100 and 0x100+4*ENTRIES share an index. Train the first, query the second -> tag miss, pred_taken_o=0.
//  6. Same-cycle predict and update at pc 0x100 -> old prediction seen, new one next cycle.
//     flush_i=1 with a valid resolve -> no pulse and no table change.
//     rst_i during training -> all counters and BTB cleared.

Source files
------------

// File: rtl/pkg_config.sv
// Shared configuration: datapath width, branch op encodings and the
// branch-predictor table entry layout with its default sizing.
package pkg_config;

    localparam int DATA_WIDTH = 32;

    localparam logic [2:0] BRANCH_BEQ      = 3'd0;
    localparam logic [2:0] BRANCH_BNE      = 3'd1;
    localparam logic [2:0] BRANCH_BLT      = 3'd2;
    localparam logic [2:0] BRANCH_BGE      = 3'd3;
    localparam logic [2:0] BRANCH_BLTU     = 3'd4;
    localparam logic [2:0] BRANCH_BGEU     = 3'd5;
    localparam logic [2:0] BRANCH_JAL_JALR = 3'd6;

    localparam int BP_ENTRIES_DEF = 64;
    localparam int BP_CNT_W_DEF   = 2;

    // Tag is stored zero-extended to the full width so the entry layout
    // does not depend on the table depth chosen by each instance.
    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] tag;
        logic [DATA_WIDTH-1:0] tgt;
    } btb_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down step for one branch-history counter; clamps at both
// ends instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (inc_i) begin
            if (cnt_i != '1) cnt_o = cnt_i + CNT_W'(1);
        end else begin
            if (cnt_i != '0) cnt_o = cnt_i - CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BHT+BTB predictor for IF, with a one-cycle registered
// EX resolve stage that reports mispredicts and trains the tables.
module branch_predict_unit
    import pkg_config::*;
#(
    parameter int ENTRIES = BP_ENTRIES_DEF,
    parameter int CNT_W   = BP_CNT_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic                  pred_taken_o,
    output logic [DATA_WIDTH-1:0] pred_target_o,
    input  logic                  resolve_valid_i,
    input  logic [2:0]            branch_op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [DATA_WIDTH-1:0] resolve_pc_i,
    input  logic [DATA_WIDTH-1:0] target_i,
    input  logic                  pred_taken_i,
    input  logic [DATA_WIDTH-1:0] pred_target_i,
    input  logic                  flush_i,
    output logic                  taken_o,
    output logic                  mispredict_o,
    output logic [DATA_WIDTH-1:0] redirect_pc_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'((1 << (CNT_W - 1)) - 1);

    logic [CNT_W-1:0] cnt_q [ENTRIES];
    btb_entry_t       btb_q [ENTRIES];

    logic                  taken_q, mispredict_q;
    logic [DATA_WIDTH-1:0] redirect_pc_q;

    logic [IDX_W-1:0] p_idx, r_idx;
    logic [TAG_W-1:0] p_tag, r_tag;
    logic             p_hit, r_hit;
    logic             actual_taken, accept;
    logic [CNT_W-1:0] cnt_base, cnt_next;
    logic [1:0]       unused_pc_bits;

    assign unused_pc_bits = pc_i[1:0];

    // Predict reads the flops directly: an update on the same edge is not
    // bypassed, so IF sees the pre-update entry.
    assign p_idx         = pc_i[IDX_W+1:2];
    assign p_tag         = pc_i[DATA_WIDTH-1:IDX_W+2];
    assign p_hit         = btb_q[p_idx].valid && (btb_q[p_idx].tag == DATA_WIDTH'(p_tag));
    assign pred_taken_o  = p_hit && cnt_q[p_idx][CNT_W-1];
    assign pred_target_o = p_hit ? btb_q[p_idx].tgt : pc_i + DATA_WIDTH'(4);

    always_comb begin
        actual_taken = 1'b0;
        case (branch_op_i)
            BRANCH_BEQ:      actual_taken = (a_i == b_i);
            BRANCH_BNE:      actual_taken = (a_i != b_i);
            BRANCH_BLT:      actual_taken = ($signed(a_i) <  $signed(b_i));
            BRANCH_BGE:      actual_taken = ($signed(a_i) >= $signed(b_i));
            BRANCH_BLTU:     actual_taken = (a_i <  b_i);
            BRANCH_BGEU:     actual_taken = (a_i >= b_i);
            BRANCH_JAL_JALR: actual_taken = 1'b1;
            default:         actual_taken = 1'b0;
        endcase
    end

    assign accept = resolve_valid_i && !flush_i;
    assign r_idx  = resolve_pc_i[IDX_W+1:2];
    assign r_tag  = resolve_pc_i[DATA_WIDTH-1:IDX_W+2];
    assign r_hit  = btb_q[r_idx].valid && (btb_q[r_idx].tag == DATA_WIDTH'(r_tag));

    // A missed entry belongs to another branch, so its history is discarded.
    assign cnt_base = r_hit ? cnt_q[r_idx] : CNT_WEAK;

    sat_counter #(.CNT_W(CNT_W)) u_sat_counter (
        .cnt_i (cnt_base),
        .inc_i (actual_taken),
        .cnt_o (cnt_next)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_WEAK;
                btb_q[i] <= '0;
            end
            taken_q       <= 1'b0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            mispredict_q <= 1'b0;
            if (accept) begin
                taken_q       <= actual_taken;
                mispredict_q  <= (actual_taken != pred_taken_i) ||
                                 (actual_taken && (target_i != pred_target_i));
                redirect_pc_q <= actual_taken ? target_i : resolve_pc_i + DATA_WIDTH'(4);
                cnt_q[r_idx]  <= cnt_next;
                if (actual_taken) begin
                    btb_q[r_idx] <= '{valid: 1'b1, tag: DATA_WIDTH'(r_tag), tgt: target_i};
                end
            end
        end
    end

    assign taken_o       = taken_q;
    assign mispredict_o  = mispredict_q;
    assign redirect_pc_o = redirect_pc_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: scripted training sequences,
// a table of resolve vectors, and a scoreboard of stage-register results.
module tb_branch_predict_unit;
    import pkg_config::*;

    localparam int DW = DATA_WIDTH;
    localparam int OW = DW + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] pc;
    logic          pred_taken;
    logic [DW-1:0] pred_target;
    logic          resolve_valid;
    logic [2:0]    branch_op;
    logic [DW-1:0] a, b, resolve_pc, target, pred_target_in;
    logic          pred_taken_in, flush;
    logic          taken, mispredict;
    logic [DW-1:0] redirect_pc;

    logic [OW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]    op;
        logic [DW-1:0] a, b, rpc, tgt;
        logic          pt;
        logic [DW-1:0] ptg;
        logic          e_taken, e_mis;
        logic [DW-1:0] e_redir;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .pc_i           (pc),
        .pred_taken_o   (pred_taken),
        .pred_target_o  (pred_target),
        .resolve_valid_i(resolve_valid),
        .branch_op_i    (branch_op),
        .a_i            (a),
        .b_i            (b),
        .resolve_pc_i   (resolve_pc),
        .target_i       (target),
        .pred_taken_i   (pred_taken_in),
        .pred_target_i  (pred_target_in),
        .flush_i        (flush),
        .taken_o        (taken),
        .mispredict_o   (mispredict),
        .redirect_pc_o  (redirect_pc)
    );

    task automatic check_val(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_pred(input string name, input logic [DW-1:0] qpc,
                              input logic e_t, input logic [DW-1:0] e_tgt);
        pc = qpc;
        #1;
        check_val({name, "_pred_taken"}, DW'(pred_taken), DW'(e_t));
        check_val({name, "_pred_target"}, pred_target, e_tgt);
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [DW-1:0] va, vb, rpc, tgt,
                                input logic pt, input logic [DW-1:0] ptg,
                                input logic et, em, input logic [DW-1:0] er);
        vec_t v;
        v.op = op; v.a = va; v.b = vb; v.rpc = rpc; v.tgt = tgt;
        v.pt = pt; v.ptg = ptg; v.e_taken = et; v.e_mis = em; v.e_redir = er;
        return v;
    endfunction

    task automatic drive(input logic [2:0] op, input logic [DW-1:0] va, vb, rpc, tgt,
                         input logic pt, input logic [DW-1:0] ptg, input logic fl);
        resolve_valid = 1'b1;
        branch_op = op; a = va; b = vb; resolve_pc = rpc; target = tgt;
        pred_taken_in = pt; pred_target_in = ptg; flush = fl;
    endtask

    // Expected stage outputs are queued before the edge and compared after it.
    task automatic tick(input string name, input logic et, em, input logic [DW-1:0] er);
        logic [OW-1:0] e;
        exp_q.push_back({et, em, er});
        @(posedge clk);
        #1;
        resolve_valid = 1'b0;
        flush = 1'b0;
        e = exp_q.pop_front();
        check_val({name, "_taken"}, DW'(taken), DW'(e[OW-1]));
        check_val({name, "_mispredict"}, DW'(mispredict), DW'(e[OW-2]));
        check_val({name, "_redirect"}, redirect_pc, e[DW-1:0]);
    endtask

    initial begin
        rst = 1'b1; pc = 32'h100; resolve_valid = 1'b0; flush = 1'b0;
        branch_op = '0; a = '0; b = '0; resolve_pc = '0; target = '0;
        pred_taken_in = 1'b0; pred_target_in = '0;

        // Reset behaviour, including a resolve offered while in reset
        @(posedge clk); #1;
        drive(BRANCH_BEQ, 5, 5, 32'h100, 32'h200, 1'b0, 0, 1'b0);
        tick("rst_hold", 1'b0, 1'b0, 0);
        check_pred("rst_during", 32'h100, 1'b0, 32'h104);
        rst = 1'b0;
        tick("rst_after", 1'b0, 1'b0, 0);
        check_pred("rst_pred", 32'h100, 1'b0, 32'h104);

        // First taken branch trains entry for 0x100
        drive(BRANCH_BEQ, 5, 5, 32'h100, 32'h200, 1'b0, 0, 1'b0);
        tick("beq_first", 1'b1, 1'b1, 32'h200);
        check_pred("beq_trained", 32'h100, 1'b1, 32'h200);
        tick("idle_hold", 1'b1, 1'b0, 32'h200);

        // Saturation walk at 0x180: 1->2->3->3->2->1
        for (int i = 0; i < 3; i++) begin
            drive(BRANCH_JAL_JALR, 0, 0, 32'h180, 32'h400, 1'b1, 32'h400, 1'b0);
            tick("sat_taken", 1'b1, 1'b0, 32'h400);
        end
        check_pred("sat_top", 32'h180, 1'b1, 32'h400);
        drive(BRANCH_BNE, 5, 5, 32'h180, 32'h400, 1'b1, 32'h400, 1'b0);
        tick("sat_nt1", 1'b0, 1'b1, 32'h184);
        check_pred("sat_after_nt1", 32'h180, 1'b1, 32'h400);
        drive(BRANCH_BNE, 5, 5, 32'h180, 32'h400, 1'b1, 32'h400, 1'b0);
        tick("sat_nt2", 1'b0, 1'b1, 32'h184);
        check_pred("sat_after_nt2", 32'h180, 1'b0, 32'h400);

        // Comparator vectors
        vecs[0]  = mk(BRANCH_BLT,  32'hFFFFFFFF, 1, 32'h620, 32'h700, 1, 32'h700, 1, 0, 32'h700);
        vecs[1]  = mk(BRANCH_BLTU, 32'hFFFFFFFF, 1, 32'h624, 32'h710, 0, 0,       0, 0, 32'h628);
        vecs[2]  = mk(BRANCH_BGE,  32'hFFFFFFFF, 1, 32'h628, 32'h720, 1, 32'h720, 0, 1, 32'h62C);
        vecs[3]  = mk(BRANCH_BGEU, 32'hFFFFFFFF, 1, 32'h62C, 32'h730, 1, 0,       1, 1, 32'h730);
        vecs[4]  = mk(BRANCH_BNE,  3, 4,            32'h630, 32'h740, 0, 0,       1, 1, 32'h740);
        vecs[5]  = mk(BRANCH_BEQ,  3, 4,            32'h634, 32'h750, 0, 0,       0, 0, 32'h638);
        vecs[6]  = mk(BRANCH_JAL_JALR, 0, 0,        32'h638, 32'h760, 1, 32'h760, 1, 0, 32'h760);
        vecs[7]  = mk(3'd7,        5, 5,            32'h63C, 32'h770, 0, 0,       0, 0, 32'h640);
        vecs[8]  = mk(BRANCH_BLT,  5, 32'hFFFFFFFD, 32'h640, 32'h780, 0, 0,       0, 0, 32'h644);
        vecs[9]  = mk(BRANCH_BGE,  32'hFFFFFFFD, 32'hFFFFFFFD, 32'h644, 32'h790, 0, 0, 1, 1, 32'h790);
        vecs[10] = mk(BRANCH_BEQ,  1, 2,            32'hFFFFFFFC, 32'h7A0, 0, 0,  0, 0, 32'h0);
        vecs[11] = mk(BRANCH_BLTU, 1, 32'hFFFFFFFF, 32'h648, 32'h7B0, 1, 32'h7B4, 1, 1, 32'h7B0);
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rpc, vecs[i].tgt,
                  vecs[i].pt, vecs[i].ptg, 1'b0);
            tick($sformatf("vec%0d", i), vecs[i].e_taken, vecs[i].e_mis, vecs[i].e_redir);
        end

        // Random equal-operand BEQs, all taken and unpredicted
        for (int i = 0; i < 4; i++) begin
            logic [DW-1:0] rv, rt;
            rv = $urandom;
            rt = DW'($urandom_range(32'h100, 32'h3FFF)) << 2;
            drive(BRANCH_BEQ, rv, rv, 32'hAC0 + DW'(4 * i), rt, 1'b0, 0, 1'b0);
            tick($sformatf("rand%0d", i), 1'b1, 1'b1, rt);
        end

        // Aliasing: same index, different tag
        check_pred("alias", 32'h100 + 32'd4 * 32'd64, 1'b0, 32'h204);
        check_pred("alias_orig", 32'h100, 1'b1, 32'h200);

        // Same-cycle predict and update: old value until the edge
        drive(BRANCH_BEQ, 1, 2, 32'h100, 32'h200, 1'b1, 32'h200, 1'b0);
        check_pred("same_cycle_old", 32'h100, 1'b1, 32'h200);
        tick("same_cycle", 1'b0, 1'b1, 32'h104);
        check_pred("same_cycle_new", 32'h100, 1'b0, 32'h200);

        // Flushed resolve: no pulse, outputs hold, tables untouched
        drive(BRANCH_BEQ, 5, 5, 32'h100, 32'h300, 1'b0, 0, 1'b1);
        tick("flush", 1'b0, 1'b0, 32'h104);
        check_pred("flush_table", 32'h100, 1'b0, 32'h200);

        // Reset in the middle of training clears everything
        drive(BRANCH_BEQ, 5, 5, 32'h180, 32'h500, 1'b0, 0, 1'b0);
        rst = 1'b1;
        tick("mid_rst", 1'b0, 1'b0, 0);
        rst = 1'b0;
        tick("mid_rst_idle", 1'b0, 1'b0, 0);
        check_pred("mid_rst_100", 32'h100, 1'b0, 32'h104);
        check_pred("mid_rst_180", 32'h180, 1'b0, 32'h184);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
